parallel_converter_k_to_n: RTL and testbench

Accumulates K tagged blocks per input beat into an N-lane output word: the next generation of the 1-to-N lane converter, with a wider input, a ready/valid output stage, frame realignment and sticky error flags. It sits between the 100GbE PCS block pipeline (encoder/scrambler side) and the per-lane distribution logic. The output word is fully registered and is held until the consumer accepts it.

---
 rtl/parallel_converter_k_to_n.sv | 82 ++++++++
 tb/tb_parallel_converter_k_to_n.sv | 118 +++++++++++
 2 files changed

// File: rtl/parallel_converter_k_to_n.sv
// parallel_converter_k_to_n: packs N_IN_LANES-block beats into an N_LANES-block word behind a held ready/valid register.
// Optional sticky status flags are built only when PARALLEL_CONVERTER_STATUS_EN is defined.
module parallel_converter_k_to_n #(
  parameter int LEN_TAGGED_BLOCK = 67,
  parameter int N_LANES = 20,
  parameter int N_IN_LANES = 4,
  parameter int NB_IN_BUS = LEN_TAGGED_BLOCK*N_IN_LANES,
  parameter int NB_DATA_BUS = LEN_TAGGED_BLOCK*N_LANES,
  localparam int N_BEATS = N_LANES/N_IN_LANES,
  localparam int NB_INDEX = (N_BEATS > 1) ? $clog2(N_BEATS) : 1
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_valid,
  input  logic                   i_sof,
  input  logic [NB_IN_BUS-1:0]   i_data,
  input  logic                   i_ready,
  input  logic                   i_clear_status,
  output logic                   o_valid,
  output logic [NB_DATA_BUS-1:0] o_data,
  output logic [NB_INDEX-1:0]    o_index,
  output logic                   o_overflow,
  output logic                   o_misalign
);
  if (N_LANES % N_IN_LANES != 0) begin : g_bad_ratio
    $error("N_IN_LANES must divide N_LANES");
  end
  logic [NB_DATA_BUS-1:0] r_accum, r_data, w_word;
  logic [NB_INDEX-1:0]    r_index, w_slot;
  logic                   r_valid, w_accept, w_complete, w_load, w_drop, w_realign;
  assign w_accept   = i_enable & i_valid;
  assign w_slot     = (w_accept & i_sof) ? '0 : r_index;
  assign w_complete = w_accept & (w_slot == NB_INDEX'(N_BEATS-1));
  assign w_load     = w_complete & (~r_valid | i_ready);
  assign w_drop     = w_complete & r_valid & ~i_ready;
  assign w_realign  = w_accept & i_sof & (r_index != '0);
  if (N_BEATS == 1) begin : g_single
    assign w_word = i_data;
  end else begin : g_multi
    assign w_word = {r_accum[NB_DATA_BUS-1 -: NB_DATA_BUS-NB_IN_BUS], i_data};
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_accum <= '0;
      r_data  <= '0;
      r_index <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) r_index <= w_complete ? '0 : w_slot + 1'b1;
      for (int j = 0; j < N_BEATS; j++)
        if (w_accept && int'(w_slot) == j) r_accum[NB_DATA_BUS-1-j*NB_IN_BUS -: NB_IN_BUS] <= i_data;
      if (w_load) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (i_ready) r_valid <= 1'b0;
    end
  end
`ifdef PARALLEL_CONVERTER_STATUS_EN
  logic r_overflow, r_misalign;
  // a set event in the same cycle as a clear wins
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_overflow <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_overflow <= w_drop | (r_overflow & ~i_clear_status);
      r_misalign <= w_realign | (r_misalign & ~i_clear_status);
    end
  end
  assign o_overflow = r_overflow;
  assign o_misalign = r_misalign;
`else
  logic w_unused;
  assign w_unused   = i_clear_status | w_drop | w_realign;
  assign o_overflow = 1'b0;
  assign o_misalign = 1'b0;
`endif
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_index = r_index;
endmodule

// File: tb/tb_parallel_converter_k_to_n.sv
// tb_parallel_converter_k_to_n: directed test-plan scenarios plus random traffic checked against a queue-based word model.
module tb_parallel_converter_k_to_n;
  localparam int L = 67, NL = 20, NI = 4, NB_IN = L*NI, NB_DATA = L*NL, NBEATS = NL/NI, NB_IDX = 3;
  logic clk = 1'b0;
  logic i_reset, i_enable, i_valid, i_sof, i_ready, i_clear_status;
  logic [NB_IN-1:0] i_data;
  logic o_valid, o_overflow, o_misalign;
  logic [NB_DATA-1:0] o_data;
  logic [NB_IDX-1:0] o_index;
  int checks = 0, errors = 0;
  logic [NB_IN-1:0] q[$];
  logic m_valid, m_ov, m_mis;
  logic [NB_DATA-1:0] m_data;
  always #5 clk = ~clk;
  parallel_converter_k_to_n dut (
    .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid), .i_sof(i_sof),
    .i_data(i_data), .i_ready(i_ready), .i_clear_status(i_clear_status), .o_valid(o_valid),
    .o_data(o_data), .o_index(o_index), .o_overflow(o_overflow), .o_misalign(o_misalign)
  );
  task automatic chk(input string tag, input logic [NB_DATA-1:0] got, input logic [NB_DATA-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [NB_IN-1:0] beat(input int b);
    logic [NB_IN-1:0] d = '0;
    for (int k = 0; k < NI; k++) d[NB_IN-1-k*L -: L] = L'(b+k);
    return d;
  endfunction
  function automatic logic [NB_IN-1:0] rnd_beat();
    logic [NB_IN-1:0] d = '0;
    for (int k = 0; k < 9; k++) d = {d[NB_IN-33:0], 32'($urandom)};
    return d;
  endfunction
  task automatic step(input logic rst, en, v, s, input logic [NB_IN-1:0] d, input logic rdy, clr);
    logic [NB_DATA-1:0] w;
    logic done, set_ov, set_mis;
    i_reset = rst; i_enable = en; i_valid = v; i_sof = s; i_data = d; i_ready = rdy; i_clear_status = clr;
    @(posedge clk);
    if (rst) begin
      q.delete(); m_valid = 0; m_data = '0; m_ov = 0; m_mis = 0;
    end else begin
      done = 0; set_ov = 0; set_mis = 0;
      if (en && v) begin
        if (s) begin
          set_mis = q.size() != 0;
          q.delete();
        end
        q.push_back(d);
        if (q.size() == NBEATS) begin
          w = '0;
          for (int i = 0; i < NBEATS; i++) w[NB_DATA-1-i*NB_IN -: NB_IN] = q[i];
          done = 1;
          q.delete();
        end
      end
      if (done && (!m_valid || rdy)) begin
        m_data = w; m_valid = 1;
      end else begin
        if (done) set_ov = 1;
        if (m_valid && rdy) m_valid = 0;
      end
      m_ov  = set_ov  | (m_ov  & ~clr);
      m_mis = set_mis | (m_mis & ~clr);
    end
    #1;
    chk("o_valid", NB_DATA'(o_valid), NB_DATA'(m_valid));
    chk("o_data", o_data, m_data);
    chk("o_index", NB_DATA'(o_index), NB_DATA'(q.size()));
`ifdef PARALLEL_CONVERTER_STATUS_EN
    chk("o_overflow", NB_DATA'(o_overflow), NB_DATA'(m_ov));
    chk("o_misalign", NB_DATA'(o_misalign), NB_DATA'(m_mis));
`else
    chk("o_overflow", NB_DATA'(o_overflow), '0);
    chk("o_misalign", NB_DATA'(o_misalign), '0);
`endif
  endtask
  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, '0, rdy, 0);
  endtask
  initial begin
    step(1, 0, 0, 0, '0, 0, 0);
    step(1, 0, 0, 0, '0, 0, 0);
    for (int b = 0; b < 5; b++) step(0, 1, 1, 0, beat(b*4), 1, 0);
    chk("first_lane0", NB_DATA'(o_data[NB_DATA-1 -: L]), NB_DATA'(0));
    chk("first_lane7", NB_DATA'(o_data[NB_DATA-1-7*L -: L]), NB_DATA'(7));
    chk("first_lane19", NB_DATA'(o_data[L-1:0]), NB_DATA'(19));
    idle(1, 2);
    for (int b = 0; b < 10; b++) step(0, 1, 1, 0, beat(20+b*4), 0, 0);
    chk("held_lane0", NB_DATA'(o_data[NB_DATA-1 -: L]), NB_DATA'(20));
    idle(0, 2);
    idle(1, 3);
    step(0, 1, 1, 0, '0, 1, 1);
    for (int b = 0; b < 2; b++) step(0, 1, 1, 0, beat(100+b*4), 1, 0);
    for (int b = 0; b < 5; b++) step(0, 1, 1, b == 0, beat(200+b*4), 1, 0);
    chk("sof_lane0", NB_DATA'(o_data[NB_DATA-1 -: L]), NB_DATA'(200));
    idle(1, 2);
    for (int b = 0; b < 15; b++) step(0, 1, 1, b % 5 == 0, beat(300+b*4), 1, 0);
    idle(1, 2);
    for (int b = 0; b < 2; b++) step(0, 1, 1, 0, beat(400+b*4), 1, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, i == 3, beat(900), 1, 0);
    chk("hold_index", NB_DATA'(o_index), NB_DATA'(2));
    for (int b = 2; b < 5; b++) step(0, 1, 1, 0, beat(400+b*4), 1, 0);
    idle(1, 2);
    for (int b = 0; b < 4; b++) step(0, 1, 1, 0, beat(500+b*4), 1, 0);
    step(1, 1, 1, 0, beat(516), 1, 0);
    chk("rst_valid", NB_DATA'(o_valid), '0);
    for (int b = 0; b < 5; b++) step(0, 1, 1, 0, beat(600+b*4), 1, 0);
    idle(1, 2);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(99) == 0, $urandom_range(9) != 0, $urandom_range(9) < 8,
           $urandom_range(9) == 0, rnd_beat(), $urandom_range(9) < 6, $urandom_range(19) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
